// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO: brings the uart_clk-domain rx_complete strobe into system_clk
// and queues {error, byte} words in a first-word-fall-through buffer with overflow tracking.
module uart_rx_fifo #(
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int DROP_ERR = 0
) (
   input  logic              system_clk,
   input  logic              reset,
   input  logic              rx_complete,
   input  logic [7:0]        rx_data,
   input  logic [1:0]        rx_error_bit,
   input  logic              rd_en,
   output logic [7:0]        rd_data,
   output logic [1:0]        rd_error,
   output logic              rd_valid,
   output logic [ADDR_W:0]   fifo_count,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              overflow,
   input  logic              overflow_clr,
   output logic [7:0]        drop_count
);

   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

   logic                r_s1, r_s2, r_s3;
   logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr;
   logic [ADDR_W:0]     r_count;
   logic                r_overflow;
   logic [7:0]          r_drop_count;
   logic [9:0]          r_mem [DEPTH];

   logic w_wr_strobe, w_filtered, w_accept, w_full, w_empty;
   logic w_pop, w_write, w_ovf_event;

   // Flops preset to 1 so a level already high at reset release is not seen as a rising edge.
   always_ff @(posedge system_clk) begin
      if (!reset) begin
         r_s1 <= 1'b1;
         r_s2 <= 1'b1;
         r_s3 <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make the three flops shift in one clock instead of collapsing.
         r_s1 <= rx_complete;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_wr_strobe = r_s2 & ~r_s3;
   assign w_filtered  = (DROP_ERR != 0) && (rx_error_bit != 2'b00);
   assign w_accept    = w_wr_strobe & ~w_filtered;
   assign w_full      = (r_count == LP_DEPTH);
   assign w_empty     = (r_count == '0);
   assign w_pop       = rd_en & ~w_empty;
   assign w_write     = w_accept & (~w_full | w_pop);
   assign w_ovf_event = w_accept & w_full & ~w_pop;

   always_ff @(posedge system_clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_write) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         if (w_pop)   r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
            2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage has no reset; the empty-forcing on the read port hides stale contents.
   always_ff @(posedge system_clk) begin
      if (w_write) r_mem[r_wr_ptr] <= {rx_error_bit, rx_data};
   end

   // A drop in the same cycle as a clear wins, leaving exactly one recorded loss.
   always_ff @(posedge system_clk) begin
      if (!reset) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (w_ovf_event) begin
         r_overflow   <= 1'b1;
         if (overflow_clr)               r_drop_count <= 8'd1;
         else if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end else if (overflow_clr) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end
   end

   assign {rd_error, rd_data} = w_empty ? 10'd0 : r_mem[r_rd_ptr];
   assign rd_valid   = ~w_empty;
   assign fifo_count = r_count;
   assign fifo_full  = w_full;
   assign fifo_empty = w_empty;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;

endmodule
